// File: rtl/ad9767_dds_if.sv
// Settings bus from the register block plus the AD9767 pin group, seen from the DDS.
// The master side drives settings and observes the DAC pins; the slave is the DDS.
interface ad9767_dds_if #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 14
);
  logic               i_en;
  logic               i_load;
  logic               i_sync;
  logic [PHASE_W-1:0] i_ftw0;
  logic [PHASE_W-1:0] i_ftw1;
  logic [PHASE_W-1:0] i_poff0;
  logic [PHASE_W-1:0] i_poff1;
  logic [7:0]         i_amp0;
  logic [7:0]         i_amp1;
  logic               o_dac_clk;
  logic [DATA_W-1:0]  o_dac_data0;
  logic [DATA_W-1:0]  o_dac_data1;

  modport master (
    output i_en, i_load, i_sync, i_ftw0, i_ftw1, i_poff0, i_poff1, i_amp0, i_amp1,
    input  o_dac_clk, o_dac_data0, o_dac_data1
  );

  modport slave (
    input  i_en, i_load, i_sync, i_ftw0, i_ftw1, i_poff0, i_poff1, i_amp0, i_amp1,
    output o_dac_clk, o_dac_data0, o_dac_data1
  );
endinterface

// File: rtl/ad9767_dds.sv
// Dual-channel DDS for the AD9767: phase accumulators, quarter-wave sine ROM,
// amplitude scaling and a divided DAC sample clock.
module ad9767_dds #(
  parameter int DAC_DIV  = 64,
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 8,
  parameter int DATA_W   = 14,
  parameter     LUT_FILE = "sine_qw.hex"
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  ad9767_dds_if.slave     bus
);

  localparam int CNT_W = $clog2(DAC_DIV);
  localparam int P_W   = LUT_AW + 2;
  localparam int M_W   = DATA_W - 1;
  localparam int PR_W  = DATA_W + 10;
  localparam logic [CNT_W-1:0]  STB_CNT  = CNT_W'(DAC_DIV / 4);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(DAC_DIV / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DAC_DIV - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  // Fixed-point constants for elaborating the ROM (Q48).
  localparam logic signed [127:0] PI_Q48   = 128'sd884279719003555;
  localparam logic signed [127:0] HALF_Q48 = 128'sd140737488355328;

  // ROM contents are computed at elaboration with a Q48 Taylor series, so the
  // table always matches LUT_AW/DATA_W; LUT_FILE names the equivalent image.
  function automatic logic [M_W-1:0] sine_entry(input int k);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] r;
    x    = (PI_Q48 * 128'(2 * k + 1)) >>> (LUT_AW + 2);
    x2   = (x * x) >>> 48;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (-((term * x2) >>> 48)) / 128'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * 128'((1 << M_W) - 1) + HALF_Q48) >>> 48;
    return r[M_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] scale_sample(input logic [M_W-1:0] mag,
                                                     input logic neg,
                                                     input logic [7:0] amp);
    logic signed [DATA_W:0] s;
    logic signed [PR_W-1:0] prod;
    logic signed [PR_W-1:0] shifted;
    s       = neg ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    prod    = PR_W'(s) * PR_W'($signed({1'b0, amp}));
    shifted = prod >>> 8;
    return MIDSCALE + shifted[DATA_W-1:0];
  endfunction

  logic [M_W-1:0] w_rom [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [M_W-1:0] ENTRY = sine_entry(k);
    assign w_rom[k] = ENTRY;
  end

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_stb;
  logic               r_dac_clk;
  logic               r_sync_pend;
  logic               w_sync_now;
  logic [PHASE_W-1:0] w_ftw_in  [2];
  logic [PHASE_W-1:0] w_poff_in [2];
  logic [7:0]         w_amp_in  [2];
  logic [PHASE_W-1:0] r_ftw_sh  [2];
  logic [PHASE_W-1:0] r_poff_sh [2];
  logic [7:0]         r_amp_sh  [2];
  logic [PHASE_W-1:0] w_ftw_eff [2];
  logic [PHASE_W-1:0] w_poff_eff[2];
  logic [7:0]         w_amp_eff [2];
  logic [7:0]         r_amp_act [2];
  logic [PHASE_W-1:0] r_acc     [2];
  logic [PHASE_W-1:0] w_acc_nxt [2];
  logic [P_W-1:0]     r_phase_p1[2];
  logic               r_vld_p1;
  logic               r_stb_p1;
  logic [LUT_AW-1:0]  w_idx     [2];
  logic [M_W-1:0]     r_mag_p2  [2];
  logic               r_neg_p2  [2];
  logic               r_vld_p2;
  logic               r_stb_p2;
  logic [DATA_W-1:0]  r_data    [2];

  assign w_ftw_in[0]  = bus.i_ftw0;
  assign w_ftw_in[1]  = bus.i_ftw1;
  assign w_poff_in[0] = bus.i_poff0;
  assign w_poff_in[1] = bus.i_poff1;
  assign w_amp_in[0]  = bus.i_amp0;
  assign w_amp_in[1]  = bus.i_amp1;

  assign w_cnt_nxt = (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
  assign w_stb     = (r_cnt == STB_CNT);

  // A load or sync arriving on the strobe cycle itself is honoured on that strobe.
  always_comb begin
    w_sync_now = r_sync_pend | bus.i_sync;
    for (int c = 0; c < 2; c++) begin
      w_ftw_eff[c]  = bus.i_load ? w_ftw_in[c]  : r_ftw_sh[c];
      w_poff_eff[c] = bus.i_load ? w_poff_in[c] : r_poff_sh[c];
      w_amp_eff[c]  = bus.i_load ? w_amp_in[c]  : r_amp_sh[c];
      if (w_sync_now) begin
        w_acc_nxt[c] = w_poff_eff[c];
      end else if (bus.i_en) begin
        w_acc_nxt[c] = r_acc[c] + w_ftw_eff[c];
      end else begin
        w_acc_nxt[c] = r_acc[c];
      end
      w_idx[c] = r_phase_p1[c][LUT_AW] ? ~r_phase_p1[c][LUT_AW-1:0]
                                       : r_phase_p1[c][LUT_AW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_dac_clk   <= 1'b0;
      r_sync_pend <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_stb_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_stb_p2    <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_ftw_sh[c]   <= '0;
        r_poff_sh[c]  <= '0;
        r_amp_sh[c]   <= '0;
        r_amp_act[c]  <= '0;
        r_acc[c]      <= '0;
        r_phase_p1[c] <= '0;
        r_mag_p2[c]   <= '0;
        r_neg_p2[c]   <= 1'b0;
        r_data[c]     <= MIDSCALE;
      end
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dac_clk <= (w_cnt_nxt >= HALF_CNT);
      r_stb_p1  <= w_stb;
      r_stb_p2  <= r_stb_p1;
      for (int c = 0; c < 2; c++) begin
        r_ftw_sh[c]  <= w_ftw_eff[c];
        r_poff_sh[c] <= w_poff_eff[c];
        r_amp_sh[c]  <= w_amp_eff[c];
      end

      // p1: sample strobe -- advance phase, latch settings, grab ROM address bits
      if (w_stb) begin
        r_sync_pend <= 1'b0;
        r_vld_p1    <= bus.i_en;
        for (int c = 0; c < 2; c++) begin
          r_amp_act[c]  <= w_amp_eff[c];
          r_acc[c]      <= w_acc_nxt[c];
          r_phase_p1[c] <= w_acc_nxt[c][PHASE_W-1 -: P_W];
        end
      end else begin
        r_sync_pend <= w_sync_now;
      end

      // p2: quarter-wave ROM lookup
      if (r_stb_p1) begin
        r_vld_p2 <= r_vld_p1;
        for (int c = 0; c < 2; c++) begin
          r_mag_p2[c] <= w_rom[w_idx[c]];
          r_neg_p2[c] <= r_phase_p1[c][P_W-1];
        end
      end

      // p3: sign, amplitude scale and offset to straight binary
      if (r_stb_p2) begin
        for (int c = 0; c < 2; c++) begin
          r_data[c] <= r_vld_p2 ? scale_sample(r_mag_p2[c], r_neg_p2[c], r_amp_act[c])
                                : MIDSCALE;
        end
      end
    end
  end

  assign bus.o_dac_clk   = r_dac_clk;
  assign bus.o_dac_data0 = r_data[0];
  assign bus.o_dac_data1 = r_data[1];

endmodule

// File: tb/tb_ad9767_dds.sv
// Bench for ad9767_dds: a sample-level model built from floating-point sine and
// the scaling rule tracks every DAC sample and the divided clock.
module tb_ad9767_dds;
  localparam int DAC_DIV = 64;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int DATA_W  = 14;
  localparam logic [13:0] MID = 14'h2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ad9767_dds_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) dif();

  ad9767_dds #(
    .DAC_DIV(DAC_DIV), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (dif.slave)
  );

  int g_vec = 0;
  int g_err = 0;
  int lut [256];

  int          m_cnt;
  logic [23:0] m_acc   [2];
  logic [23:0] m_sftw  [2];
  logic [23:0] m_spoff [2];
  logic [7:0]  m_samp  [2];
  bit          m_pend;
  bit          m_armed;
  logic [13:0] m_next  [2];
  logic [13:0] m_out   [2];

  function automatic logic [13:0] ref_sample(input logic [23:0] acc, input logic [7:0] amp);
    int  p, q, i, m;
    real scaled;
    p = int'(acc >> 14);
    q = p / 256;
    i = p % 256;
    if (q % 2 == 1) i = 255 - i;
    m = lut[i];
    if (q >= 2) m = -m;
    scaled = $floor(real'(m * int'(amp)) / 256.0);
    return 14'(8192 + int'(scaled));
  endfunction

  // Advance one clock: update the model from the inputs seen at this edge.
  task automatic tick();
    logic [23:0] f [2];
    logic [23:0] po [2];
    logic [7:0]  a [2];
    bit syn;
    f[0]  = dif.i_load ? dif.i_ftw0  : m_sftw[0];
    f[1]  = dif.i_load ? dif.i_ftw1  : m_sftw[1];
    po[0] = dif.i_load ? dif.i_poff0 : m_spoff[0];
    po[1] = dif.i_load ? dif.i_poff1 : m_spoff[1];
    a[0]  = dif.i_load ? dif.i_amp0  : m_samp[0];
    a[1]  = dif.i_load ? dif.i_amp1  : m_samp[1];
    if (!rst_n) begin
      m_cnt = 0; m_pend = 0; m_armed = 0;
      for (int c = 0; c < 2; c++) begin
        m_acc[c] = 0; m_sftw[c] = 0; m_spoff[c] = 0; m_samp[c] = 0; m_out[c] = MID;
      end
    end else begin
      if (m_cnt == DAC_DIV / 4 + 2 && m_armed) begin
        m_out[0] = m_next[0];
        m_out[1] = m_next[1];
        m_armed  = 0;
      end
      syn = m_pend || dif.i_sync;
      for (int c = 0; c < 2; c++) begin
        m_sftw[c] = f[c]; m_spoff[c] = po[c]; m_samp[c] = a[c];
      end
      if (m_cnt == DAC_DIV / 4) begin
        for (int c = 0; c < 2; c++) begin
          if (syn) m_acc[c] = po[c];
          else if (dif.i_en) m_acc[c] = m_acc[c] + f[c];
          m_next[c] = dif.i_en ? ref_sample(m_acc[c], a[c]) : MID;
        end
        m_pend  = 0;
        m_armed = 1;
      end else begin
        m_pend = syn;
      end
      m_cnt = (m_cnt + 1) % DAC_DIV;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic goto_count(input int c);
    for (int n = 0; n < DAC_DIV && m_cnt != c; n++) tick();
  endtask

  task automatic pulse_load();
    dif.i_load = 1'b1; tick(); dif.i_load = 1'b0;
  endtask

  task automatic pulse_sync();
    dif.i_sync = 1'b1; tick(); dif.i_sync = 1'b0;
  endtask

  task automatic test_reset();
    int  rise, per;
    bit  prev, done;
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      g_vec++;
      if (dif.o_dac_data0 !== MID || dif.o_dac_data1 !== MID || dif.o_dac_clk !== 1'b0) begin
        g_err++;
        $display("FAIL reset_state: got d0=%h d1=%h clk=%b, want d0=%h d1=%h clk=0",
                 dif.o_dac_data0, dif.o_dac_data1, dif.o_dac_clk, MID, MID);
      end
    end
    rst_n = 1'b1;
    rise = -1;
    for (int n = 1; n <= 100 && rise < 0; n++) begin
      tick();
      if (dif.o_dac_clk === 1'b1) rise = n;
    end
    g_vec++;
    if (rise != 32) begin
      g_err++;
      $display("FAIL first_rise: got cycle %0d, want 32", rise);
    end
    per = 0; prev = 1'b1; done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      per++;
      if (!prev && dif.o_dac_clk === 1'b1) done = 1;
      prev = (dif.o_dac_clk === 1'b1);
    end
    g_vec++;
    if (per != 64) begin
      g_err++;
      $display("FAIL clk_period: got %0d, want 64", per);
    end
  endtask

  task automatic test_sine_ch0();
    logic [13:0] q [$];
    goto_count(0);
    dif.i_en = 1'b1; dif.i_ftw0 = 24'h400000; dif.i_poff0 = 24'h0; dif.i_amp0 = 8'd255;
    pulse_load();
    pulse_sync();
    repeat (5 * DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL sine_ch0: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
      if (m_cnt == 19) q.push_back(dif.o_dac_data0);
    end
    g_vec++;
    if (q.size() != 5 || q[1] !== 14'd16351 || q[4] !== q[0]) begin
      g_err++;
      $display("FAIL sine_pattern: got n=%0d s1=%0d s0=%0d s4=%0d, want n=5 s1=16351 s4=s0",
               q.size(), q[1], q[0], q[4]);
    end
  endtask

  task automatic test_const_ch1();
    goto_count(0);
    dif.i_ftw1 = 24'h0; dif.i_poff1 = 24'h800000; dif.i_amp1 = 8'd128;
    pulse_load();
    pulse_sync();
    repeat (4 * DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL const_ch1: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
      if (m_cnt == 19) begin
        g_vec++;
        if (dif.o_dac_data1 !== 14'd8179) begin
          g_err++;
          $display("FAIL ch1_level: got %0d, want 8179", dif.o_dac_data1);
        end
      end
    end
  endtask

  task automatic test_load_timing();
    logic [13:0] d0_18, d1_18, d0_19, d1_19;
    d0_18 = '0; d1_18 = '0; d0_19 = '0; d1_19 = '0;
    goto_count(10);
    dif.i_ftw0 = 24'h100000; dif.i_ftw1 = 24'h080000;
    pulse_load();
    while (m_cnt != 21) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL load_timing: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
      if (m_cnt == 18) begin d0_18 = dif.o_dac_data0; d1_18 = dif.o_dac_data1; end
      if (m_cnt == 19) begin d0_19 = dif.o_dac_data0; d1_19 = dif.o_dac_data1; end
    end
    g_vec++;
    if (d0_19 === d0_18 || d1_19 === d1_18) begin
      g_err++;
      $display("FAIL atomic_update: got d0 %0d->%0d d1 %0d->%0d, want both to change at count 19",
               d0_18, d0_19, d1_18, d1_19);
    end
  endtask

  task automatic test_negative_ftw();
    logic [13:0] q [$];
    goto_count(0);
    dif.i_ftw0 = 24'hFFFFFF; dif.i_poff0 = 24'h000002; dif.i_amp0 = 8'd255;
    pulse_load();
    pulse_sync();
    repeat (5 * DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL negative_ftw: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
      if (m_cnt == 19) q.push_back(dif.o_dac_data0);
    end
    g_vec++;
    if (q.size() != 5 || q[2] !== 14'd8216 || q[3] !== 14'd8167 || q[4] !== 14'd8167) begin
      g_err++;
      $display("FAIL phase_wrap: got n=%0d s2=%0d s3=%0d s4=%0d, want n=5 s2=8216 s3=8167 s4=8167",
               q.size(), q[2], q[3], q[4]);
    end
  endtask

  task automatic test_enable();
    goto_count(30);
    dif.i_en = 1'b0;
    repeat (DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL disable: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
      if (m_cnt == 19) begin
        g_vec++;
        if (dif.o_dac_data0 !== MID || dif.o_dac_data1 !== MID) begin
          g_err++;
          $display("FAIL midscale: got d0=%h d1=%h, want %h", dif.o_dac_data0, dif.o_dac_data1, MID);
        end
      end
    end
    goto_count(30);
    dif.i_en = 1'b1;
    repeat (3 * DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL reenable: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    goto_count(30);
    dif.i_poff0 = 24'h123456; dif.i_poff1 = 24'h654321;
    pulse_load();
    pulse_sync();
    goto_count(40);
    rst_n = 1'b0;
    tick();
    g_vec++;
    if (dif.o_dac_data0 !== MID || dif.o_dac_data1 !== MID || dif.o_dac_clk !== 1'b0) begin
      g_err++;
      $display("FAIL midrun_reset: got d0=%h d1=%h clk=%b, want d0=%h d1=%h clk=0",
               dif.o_dac_data0, dif.o_dac_data1, dif.o_dac_clk, MID, MID);
    end
    rst_n = 1'b1;
    tick();
    dif.i_ftw0 = 24'h400000; dif.i_ftw1 = 24'h200000;
    dif.i_amp0 = 8'd255; dif.i_amp1 = 8'd200;
    pulse_load();
    repeat (3 * DAC_DIV) begin
      tick();
      g_vec++;
      if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
        g_err++;
        $display("FAIL after_reset: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                 m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      goto_count($urandom_range(0, DAC_DIV - 1));
      dif.i_ftw0  = 24'($urandom); dif.i_ftw1  = 24'($urandom);
      dif.i_poff0 = 24'($urandom); dif.i_poff1 = 24'($urandom);
      dif.i_amp0  = 8'($urandom);  dif.i_amp1  = 8'($urandom);
      dif.i_en    = ($urandom_range(0, 3) != 0);
      pulse_load();
      if ($urandom_range(0, 1) == 1) pulse_sync();
      repeat (2 * DAC_DIV) begin
        tick();
        g_vec++;
        if ({dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1} !== {m_cnt >= 32, m_out[0], m_out[1]}) begin
          g_err++;
          $display("FAIL random_%0d: cnt=%0d got clk=%b d0=%0d d1=%0d want clk=%b d0=%0d d1=%0d",
                   r, m_cnt, dif.o_dac_clk, dif.o_dac_data0, dif.o_dac_data1, m_cnt >= 32, m_out[0], m_out[1]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      lut[k] = $rtoi(8191.0 * $sin((k + 0.5) * 3.14159265358979323846 / 512.0) + 0.5);
    dif.i_en = 1'b0; dif.i_load = 1'b0; dif.i_sync = 1'b0;
    dif.i_ftw0 = '0; dif.i_ftw1 = '0; dif.i_poff0 = '0; dif.i_poff1 = '0;
    dif.i_amp0 = '0; dif.i_amp1 = '0;
    m_cnt = 0; m_pend = 0; m_armed = 0;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_sftw[c] = 0; m_spoff[c] = 0; m_samp[c] = 0;
      m_next[c] = MID; m_out[c] = MID;
    end
    test_reset();
    test_sine_ch0();
    test_const_ch1();
    test_load_timing();
    test_negative_ftw();
    test_enable();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", g_vec, g_err);
    $finish;
  end

endmodule
